regs_bank: RTL and testbench

//  Register file: slave side of the regs_if bus and of the regs_int_if internal port.

---
 rtl/regs_pkg.sv | 15 +
 rtl/regs_bank_ctrl.sv | 46 ++++
 rtl/regs_bank.sv | 90 +++++++++
 tb/tb_regs_bank.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// Shared register-file types and sizing helpers for regs_if, regs_int_if and regs_bank.
package regs_pkg;

    localparam int unsigned REGS_DEPTH = 16;
    localparam int unsigned REGS_WIDTH = 8;

    typedef logic [REGS_WIDTH-1:0] reg_data_t;
    typedef reg_data_t [REGS_DEPTH-1:0] reg_file_t;

    // Address width for a given depth; never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : regs_pkg

// File: rtl/regs_bank_ctrl.sv
// Registered bus-side response pipeline: read data, read/write acks and (REGS_BANK_ERR_EN) wr_err.
module regs_bank_ctrl
    import regs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = REGS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] rd_value,
`ifdef REGS_BANK_ERR_EN
    input  logic                  wr_discard,
    output logic                  wr_err,
`endif
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  data_ready,
    output logic                  write_done
);

    // One ack per sampled request; read_data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data  <= '0;
            data_ready <= 1'b0;
            write_done <= 1'b0;
        end else begin
            data_ready <= read_en;
            write_done <= write_en;
            if (read_en) begin
                read_data <= rd_value;
            end
        end
    end

`ifdef REGS_BANK_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_discard;
        end
    end
`endif

endmodule : regs_bank_ctrl

// File: rtl/regs_bank.sv
// Register file serving the regs_if bus and the regs_int_if core port.
// Optional discarded-write flag wr_err enabled by `REGS_BANK_ERR_EN.
module regs_bank
    import regs_pkg::*;
#(
    parameter  int unsigned DATA_DEPTH = REGS_DEPTH,
    parameter  int unsigned DATA_WIDTH = REGS_WIDTH,
    localparam int unsigned ADDR_WIDTH = addr_width(DATA_DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 read_en,
    input  logic                                 write_en,
    input  logic [ADDR_WIDTH-1:0]                addr,
    input  logic [DATA_WIDTH-1:0]                write_data,
    output logic [DATA_WIDTH-1:0]                read_data,
    output logic                                 data_ready,
    output logic                                 write_done,
    input  logic                                 load_regs,
    input  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] regi,
    input  logic [DATA_DEPTH-1:0]                mode_mask,
`ifdef REGS_BANK_ERR_EN
    output logic                                 wr_err,
`endif
    output logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] rego
);

    logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] regs_q;
    logic [DATA_WIDTH-1:0]                 rd_value_c;
    logic                                  in_range_c;
    logic                                  ro_target_c;
    logic                                  wr_discard_c;

    // Address decode by compare so non-power-of-2 depths never index past the array.
    always_comb begin
        rd_value_c  = '0;
        in_range_c  = 1'b0;
        ro_target_c = 1'b0;
        for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                in_range_c  = 1'b1;
                rd_value_c  = regs_q[i];
                ro_target_c = mode_mask[i];
            end
        end
    end

    assign wr_discard_c = write_en & (~in_range_c | ro_target_c | load_regs);

    // Read-only entries track regi every cycle; load_regs takes priority over bus writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
                if (mode_mask[i] || load_regs) begin
                    regs_q[i] <= regi[i];
                end else if (write_en && (addr == ADDR_WIDTH'(i))) begin
                    regs_q[i] <= write_data;
                end
            end
        end
    end

    assign rego = regs_q;

    regs_bank_ctrl #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_en    (read_en),
        .write_en   (write_en),
        .rd_value   (rd_value_c),
`ifdef REGS_BANK_ERR_EN
        .wr_discard (wr_discard_c),
        .wr_err     (wr_err),
`endif
        .read_data  (read_data),
        .data_ready (data_ready),
        .write_done (write_done)
    );

`ifndef REGS_BANK_ERR_EN
    // Discard detection only feeds wr_err; keep it visible for debug in the default build.
    logic unused_discard;
    assign unused_discard = wr_discard_c;
`endif

endmodule : regs_bank

// File: tb/tb_regs_bank.sv
// Table-driven bench for regs_bank with a small expected-result queue and corner-case sequences.
module tb_regs_bank;
    import regs_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        read_en;
    logic        write_en;
    logic [3:0]  addr;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        data_ready;
    logic        write_done;
    logic        load_regs;
    reg_file_t   regi;
    logic [15:0] mode_mask;
    reg_file_t   rego;
`ifdef REGS_BANK_ERR_EN
    logic        wr_err;
`endif

    int tests_run;
    int tests_failed;

    regs_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_en    (read_en),
        .write_en   (write_en),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .data_ready (data_ready),
        .write_done (write_done),
        .load_regs  (load_regs),
        .regi       (regi),
        .mode_mask  (mode_mask),
`ifdef REGS_BANK_ERR_EN
        .wr_err     (wr_err),
`endif
        .rego       (rego)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       load;
        logic [7:0] exp_rdata;
        logic       exp_ready;
        logic       exp_done;
        logic       exp_err;
        logic [7:0] exp_reg;
    } vec_t;

    vec_t vecs[17];
    vec_t sb[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        read_en    = 1'b0;
        write_en   = 1'b0;
        load_regs  = 1'b0;
        addr       = '0;
        write_data = '0;
    endtask

    // Drive mid-cycle, queue expectation at the edge, compare just after it.
    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        read_en    = v.rd;
        write_en   = v.wr;
        addr       = v.addr;
        write_data = v.wdata;
        load_regs  = v.load;
        @(posedge clk);
        sb.push_back(v);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d data_ready", idx), 128'(data_ready), 128'(e.exp_ready));
        check($sformatf("v%0d write_done", idx), 128'(write_done), 128'(e.exp_done));
        check($sformatf("v%0d read_data", idx), 128'(read_data), 128'(e.exp_rdata));
        check($sformatf("v%0d rego[%0d]", idx, e.addr), 128'(rego[e.addr]), 128'(e.exp_reg));
`ifdef REGS_BANK_ERR_EN
        check($sformatf("v%0d wr_err", idx), 128'(wr_err), 128'(e.exp_err));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        //          rd    wr    addr   wdata  load  rdata  rdy   done  err   reg
        vecs[0]  = '{1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[1]  = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[2]  = '{1'b0, 1'b1, 4'd5, 8'hFF, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'h3C};
        vecs[3]  = '{1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[4]  = '{1'b0, 1'b1, 4'd7, 8'h10, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h10};
        vecs[5]  = '{1'b1, 1'b1, 4'd7, 8'h20, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 8'h20};
        vecs[6]  = '{1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 8'h20};
        vecs[7]  = '{1'b0, 1'b1, 4'd2, 8'h22, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 8'h11};
        vecs[8]  = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 4'd0, 8'h40, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40};
        vecs[10] = '{1'b0, 1'b1, 4'd1, 8'h41, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41};
        vecs[11] = '{1'b0, 1'b1, 4'd3, 8'h43, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h43};
        vecs[12] = '{1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 8'h40};
        vecs[13] = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0, 8'h41};
        vecs[14] = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[15] = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 8'h43, 1'b1, 1'b0, 1'b0, 8'h43};
        vecs[16] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h43, 1'b0, 1'b0, 1'b0, 8'h40};

        idle_inputs();
        regi      = '0;
        regi[5]   = 8'h3C;
        regi[2]   = 8'h11;
        mode_mask = 16'h0020;
        rst_n     = 1'b0;
        #1;
        check("reset read_data", 128'(read_data), 128'h0);
        check("reset data_ready", 128'(data_ready), 128'h0);
        check("reset write_done", 128'(write_done), 128'h0);
        check("reset rego", 128'(rego), 128'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            apply(i, vecs[i]);
        end

        // Mode change takes effect only at the next edge, and clearing it keeps the data.
        @(negedge clk);
        idle_inputs();
        regi[1]      = 8'h99;
        mode_mask[1] = 1'b1;
        #1;
        check("mask pre-edge rego[1]", 128'(rego[1]), 128'h41);
        @(posedge clk);
        #1;
        check("mask ro rego[1]", 128'(rego[1]), 128'h99);
        @(negedge clk);
        mode_mask[1] = 1'b0;
        regi[1]      = 8'h77;
        @(posedge clk);
        #1;
        check("mask rw keeps rego[1]", 128'(rego[1]), 128'h99);

        // Reset asserted in the middle of a write cycle.
        @(negedge clk);
        mode_mask  = '0;
        regi       = '0;
        write_en   = 1'b1;
        addr       = 4'd0;
        write_data = 8'h55;
        @(posedge clk);
        #1;
        check("prereset write_done", 128'(write_done), 128'h1);
        check("prereset rego[0]", 128'(rego[0]), 128'h55);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset write_done", 128'(write_done), 128'h0);
        check("midreset read_data", 128'(read_data), 128'h0);
        check("midreset data_ready", 128'(data_ready), 128'h0);
        check("midreset rego", 128'(rego), 128'h0);
`ifdef REGS_BANK_ERR_EN
        check("midreset wr_err", 128'(wr_err), 128'h0);
`endif
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postreset rego", 128'(rego), 128'h0);
        check("postreset write_done", 128'(write_done), 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_regs_bank
